// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver.
// This block takes byte strobes from the UART receiver and delimits RTU frames
// using the t1.5 and t3.5 silence rules. Accepted bytes are streamed out with
// their position in the frame. The block also checks the frame with a bit-serial
// CRC-16 and matches the slave address. At frame end it reports a status
// summary with a frame_done pulse.
//
// Handshake: rx_done qualifies rx_data for exactly one cycle. byte_valid
// qualifies byte_data/byte_idx for exactly one cycle, and frame_done marks the
// cycle in which frame_ok/frame_err/frame_len/frame_bcast take their new
// values. There is no back-pressure on any interface; consumers must take the
// strobes as they come.
module modbus_rtu_frame_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic [7:0] dev_addr,
  output logic [7:0] byte_data,
  output logic [8:0] byte_idx,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [3:0] frame_err,
  output logic [8:0] frame_len,
  output logic       frame_bcast
);

  // Silence thresholds in clocks. Up to 19200 baud they scale with the bit
  // time; above that they are fixed at 750 us / 1750 us.
  localparam logic [63:0] CLK64  = 64'(CLK_FREQ);
  localparam logic [63:0] BAUD64 = 64'(BAUD_RATE);
  localparam logic [63:0] BT64   = CLK64 / BAUD64;
  localparam logic [63:0] T15_64 = (BAUD_RATE <= 32'd19200) ?
                                   (BT64 * 64'd33) / 64'd2 :
                                   (CLK64 * 64'd750) / 64'd1000000;
  localparam logic [63:0] T35_64 = (BAUD_RATE <= 32'd19200) ?
                                   (BT64 * 64'd77) / 64'd2 :
                                   (CLK64 * 64'd1750) / 64'd1000000;
  localparam logic [31:0] T15       = T15_64[31:0];
  localparam logic [31:0] T35       = T35_64[31:0];
  localparam logic [8:0]  MAX_LEN_V = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,  // waiting for bus silence after reset
    S_IDLE = 3'd1,  // between frames, next byte is an address byte
    S_RECV = 3'd2,  // inside a frame, bytes arrive within t1.5
    S_GAP  = 3'd3,  // t1.5 passed, waiting for t3.5 to close the frame
    S_DONE = 3'd4   // one-cycle frame_done window
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [8:0]  len_q, len_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        ovf_q, ovf_d;
  logic        gap_q, gap_d;
  logic        addr_match_q, addr_match_d;
  logic        bcast_q, bcast_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic [3:0]  frame_err_q, frame_err_d;
  logic [8:0]  frame_len_q, frame_len_d;
  logic        frame_bcast_q, frame_bcast_d;

  // Set by the FSM to push rx_data into the CRC shifter, with or without
  // reseeding the CRC register.
  logic        crc_feed;
  logic        crc_init;
  logic [3:0]  fin_err;

  // Silence timer: restarts on every byte, otherwise counts up and sticks at t3.5.
  always_comb begin
    timer_d = timer_q;
    if (rx_done) begin
      timer_d = '0;
    end else if (timer_q < T35) begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Bit-serial CRC-16 (reflected 0xA001): one bit per clock, eight clocks per
  // byte. The minimum bit time guarantees it is idle before the next byte.
  always_comb begin
    crc_d    = crc_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    if (crc_feed) begin
      sh_d     = rx_data;
      bitcnt_d = 4'd8;
      if (crc_init) begin
        crc_d = 16'hFFFF;
      end
    end else if (bitcnt_q != 4'd0) begin
      crc_d    = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ sh_q[0]) ? 16'hA001 : 16'h0000);
      sh_d     = {1'b0, sh_q[7:1]};
      bitcnt_d = bitcnt_q - 4'd1;
    end
  end

  // Frame FSM next-state, byte streaming and end-of-frame summary.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    ovf_d         = ovf_q;
    gap_d         = gap_q;
    addr_match_d  = addr_match_q;
    bcast_d       = bcast_q;
    byte_data_d   = byte_data_q;
    byte_idx_d    = byte_idx_q;
    byte_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    frame_err_d   = frame_err_q;
    frame_len_d   = frame_len_q;
    frame_bcast_d = frame_bcast_q;
    crc_feed      = 1'b0;
    crc_init      = 1'b0;
    // CRC residue over the whole frame, CRC bytes included, is zero when good.
    fin_err       = {gap_q, ovf_q, (len_q < 9'd4), (crc_q != 16'h0000)};

    case (state_q)
      S_INIT: begin
        // Bytes heard before the first t3.5 silence belong to a frame we
        // joined part-way through, so they are dropped.
        if (timer_q >= T35) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (rx_done) begin
          byte_valid_d = 1'b1;
          byte_data_d  = rx_data;
          byte_idx_d   = 9'd0;
          crc_feed     = 1'b1;
          crc_init     = 1'b1;
          len_d        = 9'd1;
          bcast_d      = (rx_data == 8'h00);
          addr_match_d = (rx_data == dev_addr) || (rx_data == 8'h00);
          ovf_d        = 1'b0;
          gap_d        = 1'b0;
          state_d      = S_RECV;
        end
      end

      S_RECV: begin
        if (rx_done) begin
          if (timer_q < T15) begin
            if (len_q < MAX_LEN_V) begin
              byte_valid_d = 1'b1;
              byte_data_d  = rx_data;
              byte_idx_d   = len_q;
              len_d        = len_q + 9'd1;
              crc_feed     = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            // A byte landing exactly on the t1.5 boundary already counts as
            // arriving after an inter-character gap.
            gap_d   = 1'b1;
            state_d = S_GAP;
          end
        end else if (timer_q >= T15) begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (rx_done) begin
          // Late byte: flag the gap violation and keep waiting for a clean t3.5.
          gap_d = 1'b1;
        end else if (timer_q >= T35) begin
          frame_done_d  = 1'b1;
          frame_len_d   = len_q;
          frame_err_d   = fin_err;
          frame_ok_d    = (fin_err == 4'd0) && addr_match_q;
          frame_bcast_d = bcast_q;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer and CRC engine registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_q  <= '0;
      crc_q    <= 16'hFFFF;
      sh_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      timer_q  <= timer_d;
      crc_q    <= crc_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Per-frame working state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      len_q         <= '0;
      ovf_q         <= 1'b0;
      gap_q         <= 1'b0;
      addr_match_q  <= 1'b0;
      bcast_q       <= 1'b0;
      byte_data_q   <= '0;
      byte_idx_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= '0;
      frame_len_q   <= '0;
      frame_bcast_q <= 1'b0;
    end else begin
      len_q         <= len_d;
      ovf_q         <= ovf_d;
      gap_q         <= gap_d;
      addr_match_q  <= addr_match_d;
      bcast_q       <= bcast_d;
      byte_data_q   <= byte_data_d;
      byte_idx_q    <= byte_idx_d;
      byte_valid_q  <= byte_valid_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      frame_len_q   <= frame_len_d;
      frame_bcast_q <= frame_bcast_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_idx    = byte_idx_q;
  assign byte_valid  = byte_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;
  assign frame_bcast = frame_bcast_q;

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for modbus_rtu_frame_rx. It uses a short bit time (BT = 16 clocks) so
// that full frames, overflow frames and t3.5 waits fit in a short run.
// t1.5 = 16*33/2 = 264 clocks; t3.5 = 16*77/2 = 616 clocks.
module tb_modbus_rtu_frame_rx;

  localparam int unsigned CLK_FREQ  = 153600;
  localparam int unsigned BAUD_RATE = 9600;
  localparam int unsigned MAX_LEN   = 256;
  localparam int BT  = 16;
  localparam int T15 = 264;
  localparam int T35 = 616;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] dev_addr;
  logic [7:0] byte_data;
  logic [8:0] byte_idx;
  logic       byte_valid;
  logic       frame_done;
  logic       frame_ok;
  logic [3:0] frame_err;
  logic [8:0] frame_len;
  logic       frame_bcast;

  always #5 clk = ~clk;

  modbus_rtu_frame_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .dev_addr   (dev_addr),
    .byte_data  (byte_data),
    .byte_idx   (byte_idx),
    .byte_valid (byte_valid),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .frame_len  (frame_len),
    .frame_bcast(frame_bcast)
  );

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          last_rx  = 0;
  int          vcnt     = 0;
  int          done_cnt = 0;
  int          done_lat = 0;
  logic [16:0] exp_q[$];   // {byte_idx, byte_data} expected on byte_valid

  typedef struct {
    string      name;
    logic [7:0] addr;
    int         n;
    logic [7:0] b [8];
    bit         add_crc;
    logic       exp_ok;
    logic [3:0] exp_err;
    logic [8:0] exp_len;
    logic       exp_bcast;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference Modbus CRC-16 over a byte list.
  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Cycle counter; remembers the cycle in which rx_done was last high.
  always @(posedge clk) begin
    if (rx_done) last_rx = cyc;
    cyc = cyc + 1;
  end

  // Output monitor: every byte_valid is scored against exp_q.
  always @(negedge clk) begin
    if (rst_n && byte_valid) begin
      logic [16:0] e;
      vcnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected byte_valid: got idx %0d data %02h, required no byte", byte_idx, byte_data);
      end else begin
        e = exp_q.pop_front();
        if ({byte_idx, byte_data} !== e) begin
          errors++;
          $display("FAIL byte stream: got idx %0d data %02h, required idx %0d data %02h",
                   byte_idx, byte_data, e[16:8], e[7:0]);
        end
      end
      check("byte_valid latency", 32'(cyc - last_rx), 32'd1);
    end
    if (rst_n && frame_done) begin
      done_cnt++;
      done_lat = cyc - last_rx;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; next rx_done follows 'spacing' clocks later.
  task automatic send_byte(input logic [7:0] b, input int spacing);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (spacing - 1) @(negedge clk);
  endtask

  task automatic expect_byte(input int idx, input logic [7:0] b);
    exp_q.push_back({9'(idx), b});
  endtask

  task automatic wait_frame(input string name, input int start, input logic ok,
                            input logic [3:0] err, input logic [8:0] len, input logic bc);
    int n;
    n = 0;
    while (done_cnt == start && n < T35 + 64) begin
      @(negedge clk);
      n++;
    end
    repeat (32) @(negedge clk);
    check({name, " frame_done count"}, 32'(done_cnt - start), 32'd1);
    checks++;
    // Silence is counted from the clock after the last byte; allow the
    // registered frame_done to land in either of the two adjacent cycles.
    if (done_lat < T35 + 1 || done_lat > T35 + 2) begin
      errors++;
      $display("FAIL %s frame_done latency: got %0d, required %0d..%0d", name, done_lat, T35 + 1, T35 + 2);
    end
    check({name, " frame_ok"},    32'(frame_ok),    32'(ok));
    check({name, " frame_err"},   32'(frame_err),   32'(err));
    check({name, " frame_len"},   32'(frame_len),   32'(len));
    check({name, " frame_bcast"}, 32'(frame_bcast), 32'(bc));
    check({name, " bytes left"},  32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  fb[$];
    logic [15:0] c;
    int          start;
    dev_addr = v.addr;
    for (int i = 0; i < v.n; i++) fb.push_back(v.b[i]);
    if (v.add_crc) begin
      c = crc16(fb);
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
    end
    start = done_cnt;
    for (int i = 0; i < fb.size(); i++) begin
      expect_byte(i, fb[i]);
      send_byte(fb[i], BT);
    end
    wait_frame(v.name, start, v.exp_ok, v.exp_err, v.exp_len, v.exp_bcast);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " byte_data"},   32'(byte_data),   32'd0);
    check({tag, " byte_idx"},    32'(byte_idx),    32'd0);
    check({tag, " byte_valid"},  32'(byte_valid),  32'd0);
    check({tag, " frame_done"},  32'(frame_done),  32'd0);
    check({tag, " frame_ok"},    32'(frame_ok),    32'd0);
    check({tag, " frame_err"},   32'(frame_err),   32'd0);
    check({tag, " frame_len"},   32'(frame_len),   32'd0);
    check({tag, " frame_bcast"}, 32'(frame_bcast), 32'd0);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  q[$];
    logic [7:0]  h[$];
    int          start;
    int          v0;

    // Vector table: standard read, corrupted CRC, foreign address, broadcast.
    vecs[0].name = "read_ok";   vecs[0].addr = 8'h01; vecs[0].n = 8; vecs[0].add_crc = 1'b0;
    vecs[0].b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    vecs[0].exp_ok = 1'b1; vecs[0].exp_err = 4'b0000; vecs[0].exp_len = 9'd8; vecs[0].exp_bcast = 1'b0;

    vecs[1].name = "bad_crc";   vecs[1].addr = 8'h01; vecs[1].n = 8; vecs[1].add_crc = 1'b0;
    vecs[1].b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
    vecs[1].exp_ok = 1'b0; vecs[1].exp_err = 4'b0001; vecs[1].exp_len = 9'd8; vecs[1].exp_bcast = 1'b0;

    vecs[2].name = "other_addr"; vecs[2].addr = 8'h05; vecs[2].n = 8; vecs[2].add_crc = 1'b0;
    vecs[2].b = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    vecs[2].exp_ok = 1'b0; vecs[2].exp_err = 4'b0000; vecs[2].exp_len = 9'd8; vecs[2].exp_bcast = 1'b0;

    // Broadcast write: 00 06 00 01 00 03 followed by its own CRC.
    vecs[3].name = "broadcast"; vecs[3].addr = 8'h05; vecs[3].n = 6; vecs[3].add_crc = 1'b1;
    vecs[3].b = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h00};
    vecs[3].exp_ok = 1'b1; vecs[3].exp_err = 4'b0000; vecs[3].exp_len = 9'd8; vecs[3].exp_bcast = 1'b1;

    rst_n    = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    dev_addr = 8'h01;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A byte before the first t3.5 silence is dropped.
    v0 = vcnt;
    repeat (20) @(negedge clk);
    send_byte(8'h01, BT);
    repeat (8) @(negedge clk);
    check("init byte ignored", 32'(vcnt), 32'(v0));
    repeat (2 * T35) @(negedge clk);

    // Table-driven frames.
    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // t1.5 violation: 20 BT pause after the third byte.
    dev_addr = 8'h01;
    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    h = '{8'h01, 8'h03, 8'h00};
    start = done_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) expect_byte(i, q[i]);
      send_byte(q[i], (i == 2) ? 20 * BT : BT);
    end
    wait_frame("gap", start, 1'b0, {1'b1, 1'b0, 1'b1, crc16(h) != 16'h0}, 9'd3, 1'b0);

    // Overflow: 258 bytes, only 256 are emitted and CRC'd.
    q.delete();
    h.delete();
    for (int i = 0; i < 258; i++) q.push_back(8'(i));
    for (int i = 0; i < 256; i++) h.push_back(8'(i));
    start = done_cnt;
    for (int i = 0; i < 258; i++) begin
      if (i < 256) expect_byte(i, q[i]);
      send_byte(q[i], BT);
    end
    wait_frame("overflow", start, 1'b0, {1'b0, 1'b1, 1'b0, crc16(h) != 16'h0}, 9'd256, 1'b1);

    // Short frame of two bytes.
    h = '{8'h01, 8'h03};
    start = done_cnt;
    expect_byte(0, 8'h01);
    send_byte(8'h01, BT);
    expect_byte(1, 8'h03);
    send_byte(8'h03, BT);
    wait_frame("short", start, 1'b0, {1'b0, 1'b0, 1'b1, crc16(h) != 16'h0}, 9'd2, 1'b0);

    // Reset in the middle of a frame: partial frame dropped, no frame_done.
    start = done_cnt;
    expect_byte(0, 8'h01);
    send_byte(8'h01, BT);
    expect_byte(1, 8'h03);
    send_byte(8'h03, BT);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    v0 = vcnt;
    send_byte(8'h01, BT);
    repeat (8) @(negedge clk);
    check("post-reset byte ignored", 32'(vcnt), 32'(v0));
    repeat (T35 + 50) @(negedge clk);
    check("midreset no frame_done", 32'(done_cnt), 32'(start));
    check("midreset scoreboard", 32'(exp_q.size()), 32'd0);

    // After t3.5 of silence the receiver accepts frames again.
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
